// File: rtl/wam_pkg.sv
// Shared Whac-A-Mole definitions: FSM state encodings, hole count and field widths.
// Pure declarations; no logic, so no latency or backpressure of its own.
package wam_pkg;

    localparam int NHOLE = 8;
    localparam int HOLEW = 3;
    localparam int SECW  = 7;

    typedef enum logic [1:0] {
        WAM_IDLE  = 2'd0,
        WAM_PLAY  = 2'd1,
        WAM_DRAIN = 2'd2,
        WAM_OVER  = 2'd3
    } wam_state_t;

endpackage

// File: rtl/wam_rr8.sv
// 8-way round-robin pick: first requesting hole at or above ptr, wrapping 7->0.
// Purely combinational, zero latency; the caller owns the pointer and decides when to take a grant.
module wam_rr8 import wam_pkg::*; (
    input  logic [NHOLE-1:0] req,
    input  logic [HOLEW-1:0] ptr,
    output logic [NHOLE-1:0] gnt,
    output logic [HOLEW-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        logic [HOLEW-1:0] idx;
        idx     = ptr;
        any     = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NHOLE; k++) begin
            idx = ptr + HOLEW'(k);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt = any ? (NHOLE'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/wam_ctl.sv
// Round sequencer and hit serialiser for the score counter; hit edge -> pending at edge k, grant/whack/scr_inc at k+1.
// Concurrent hits wait in a per-hole pending bit and are released one per 2*PULSE_W cycles in round-robin order.
module wam_ctl import wam_pkg::*; #(
    parameter int TICK_DIV = 50_000_000,
    parameter int GAME_SEC = 60,
    parameter int PULSE_W  = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [NHOLE-1:0]  mole,
    input  logic [NHOLE-1:0]  hit,
    output logic              scr_inc,
    output logic              scr_clr,
    output logic [NHOLE-1:0]  whack,
    output logic [1:0]        state,
    output logic [SECW-1:0]   sec_left
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(2 * PULSE_W);

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   PC_LAST   = CW'(2 * PULSE_W - 2);
    localparam logic [CW-1:0]   PC_HI     = CW'(PULSE_W - 1);
    localparam logic [SECW-1:0] SEC_INIT  = SECW'(GAME_SEC);

    wam_state_t       st;
    logic [TW-1:0]    tick;
    logic [NHOLE-1:0] hit_q;
    logic [NHOLE-1:0] pending;
    logic [HOLEW-1:0] ptr;
    logic             busy;
    logic [CW-1:0]    pcnt;

    logic [NHOLE-1:0] rise;
    logic [NHOLE-1:0] acc;
    logic [NHOLE-1:0] gnt;
    logic [NHOLE-1:0] gnt_mask;
    logic [HOLEW-1:0] gnt_idx;
    logic             any;
    logic             grant;
    logic             take_start;
    logic             in_round;

    assign state = st;

    wam_rr8 u_rr (
        .req     (pending),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign in_round   = (st == WAM_PLAY) || (st == WAM_DRAIN);
    assign take_start = start && ((st == WAM_IDLE) || (st == WAM_OVER));
    assign rise       = hit & ~hit_q;
    assign acc        = (st == WAM_PLAY) ? (rise & mole) : '0;
    assign grant      = !busy && any && in_round;
    assign gnt_mask   = grant ? gnt : '0;

    // Round FSM with second timer; DRAIN waits for the pulse engine and all pending hits.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st       <= WAM_IDLE;
            tick     <= '0;
            sec_left <= '0;
            scr_clr  <= 1'b0;
        end else begin
            scr_clr <= take_start;
            case (st)
                WAM_IDLE, WAM_OVER: begin
                    if (start) begin
                        st       <= WAM_PLAY;
                        sec_left <= SEC_INIT;
                        tick     <= '0;
                    end
                end
                WAM_PLAY: begin
                    if (tick == TICK_LAST) begin
                        tick     <= '0;
                        sec_left <= sec_left - 1'b1;
                        if (sec_left == SECW'(1))
                            st <= WAM_DRAIN;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                WAM_DRAIN: begin
                    if (!busy && (pending == '0))
                        st <= WAM_OVER;
                end
                default: st <= WAM_IDLE;
            endcase
        end
    end

    // Hit qualification, pending set, arbiter pointer and the score pulse engine.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hit_q   <= '0;
            pending <= '0;
            ptr     <= '0;
            whack   <= '0;
            busy    <= 1'b0;
            pcnt    <= '0;
            scr_inc <= 1'b0;
        end else begin
            hit_q <= hit;
            whack <= gnt_mask;

            // A rise on the hole being granted this cycle is dropped, not re-queued.
            if (take_start)
                pending <= '0;
            else
                pending <= (pending | acc) & ~gnt_mask;

            if (grant)
                ptr <= gnt_idx + 1'b1;

            if (grant) begin
                busy    <= 1'b1;
                pcnt    <= '0;
                scr_inc <= 1'b1;
            end else if (busy) begin
                if (pcnt == PC_LAST) begin
                    busy    <= 1'b0;
                    scr_inc <= 1'b0;
                end else begin
                    pcnt    <= pcnt + 1'b1;
                    scr_inc <= (pcnt < PC_HI);
                end
            end
        end
    end

endmodule

// File: tb/tb_wam_ctl.sv
// Directed bench for wam_ctl with TICK_DIV=10, GAME_SEC=3, PULSE_W=2.
// Expected values are hand-derived cycle positions relative to each start edge.
module tb_wam_ctl;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] mole;
    logic [7:0] hit;
    logic       scr_inc;
    logic       scr_clr;
    logic [7:0] whack;
    logic [1:0] state;
    logic [6:0] sec_left;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;
    int whacks = 0;
    logic inc_prev = 1'b0;
    int p0;
    int w0;

    wam_ctl #(
        .TICK_DIV (10),
        .GAME_SEC (3),
        .PULSE_W  (2)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .mole     (mole),
        .hit      (hit),
        .scr_inc  (scr_inc),
        .scr_clr  (scr_clr),
        .whack    (whack),
        .state    (state),
        .sec_left (sec_left)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scr_inc && !inc_prev)
            pulses++;
        if (whack != 8'h00)
            whacks++;
        inc_prev = scr_inc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        chk({tag, "_scr_clr"}, 32'(scr_clr), 32'd1);
        chk({tag, "_state"}, 32'(state), 32'd1);
        chk({tag, "_sec"}, 32'(sec_left), 32'd3);
        start = 1'b0;
    endtask

    task automatic wait_over(input string tag);
        for (int i = 0; i < 60 && state != 2'd3; i++)
            tick();
        chk(tag, 32'(state), 32'd3);
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        mole  = 8'h00;
        hit   = 8'h00;
        ticks(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_inc", 32'(scr_inc), 32'd0);
        chk("rst_clr", 32'(scr_clr), 32'd0);
        chk("rst_whack", 32'(whack), 32'd0);
        chk("rst_sec", 32'(sec_left), 32'd0);
        clr = 1'b0;
        tick();

        // Round 1: timer only
        do_start("r1");
        tick();
        chk("r1_clr_drop", 32'(scr_clr), 32'd0);
        ticks(8);
        chk("r1_sec_s9", 32'(sec_left), 32'd3);
        tick();
        chk("r1_sec_s10", 32'(sec_left), 32'd2);
        ticks(20);
        chk("r1_sec_s30", 32'(sec_left), 32'd0);
        chk("r1_drain", 32'(state), 32'd2);
        tick();
        chk("r1_over", 32'(state), 32'd3);

        // Round 2: holes 1,5,6 together from pointer 0, then 1 and 3 with pointer at 7
        do_start("r2");
        p0 = pulses;
        mole = 8'hFF;
        hit  = 8'h62;
        tick();
        chk("r2_s1_whack", 32'(whack), 32'h00);
        chk("r2_s1_inc", 32'(scr_inc), 32'd0);
        tick();
        chk("r2_g1_whack", 32'(whack), 32'h02);
        chk("r2_g1_inc", 32'(scr_inc), 32'd1);
        tick();
        chk("r2_s3_whack", 32'(whack), 32'h00);
        chk("r2_s3_inc", 32'(scr_inc), 32'd1);
        tick();
        chk("r2_s4_inc", 32'(scr_inc), 32'd0);
        ticks(2);
        chk("r2_g2_whack", 32'(whack), 32'h20);
        chk("r2_g2_inc", 32'(scr_inc), 32'd1);
        ticks(4);
        chk("r2_g3_whack", 32'(whack), 32'h40);
        hit = 8'h00;
        tick();
        hit = 8'h0A;
        ticks(3);
        chk("r2_g4_whack", 32'(whack), 32'h02);
        ticks(4);
        chk("r2_g5_whack", 32'(whack), 32'h08);
        hit = 8'h00;
        ticks(3);
        chk("r2_pulses", 32'(pulses - p0), 32'd5);
        wait_over("r2_over");

        // Round 3: single hit on hole 2, then 1 and 3 with pointer at 3, then invalid hits
        do_start("r3");
        p0 = pulses;
        mole = 8'h04;
        hit  = 8'h04;
        tick();
        chk("r3_s1_whack", 32'(whack), 32'h00);
        tick();
        chk("r3_g_whack", 32'(whack), 32'h04);
        chk("r3_g_inc", 32'(scr_inc), 32'd1);
        hit = 8'h00;
        tick();
        chk("r3_s3_whack", 32'(whack), 32'h00);
        chk("r3_s3_inc", 32'(scr_inc), 32'd1);
        tick();
        chk("r3_s4_inc", 32'(scr_inc), 32'd0);
        mole = 8'hFF;
        hit  = 8'h0A;
        ticks(2);
        chk("r3_g2_whack", 32'(whack), 32'h08);
        ticks(4);
        chk("r3_g3_whack", 32'(whack), 32'h02);
        hit = 8'h00;
        ticks(2);
        chk("r3_pulses", 32'(pulses - p0), 32'd3);
        p0 = pulses;
        w0 = whacks;
        mole = 8'h00;
        hit  = 8'hFF;
        ticks(6);
        chk("r3_inval_whack", 32'(whacks - w0), 32'd0);
        chk("r3_inval_pulses", 32'(pulses - p0), 32'd0);
        hit = 8'h00;
        wait_over("r3_over");

        // Round 4: three hits pending as the timer expires, plus a rejected hit in DRAIN
        do_start("r4");
        p0 = pulses;
        mole = 8'hFF;
        ticks(29);
        chk("r4_s29_state", 32'(state), 32'd1);
        chk("r4_s29_sec", 32'(sec_left), 32'd1);
        hit = 8'h92;
        tick();
        chk("r4_s30_state", 32'(state), 32'd2);
        chk("r4_s30_sec", 32'(sec_left), 32'd0);
        chk("r4_s30_whack", 32'(whack), 32'h00);
        hit = 8'h00;
        tick();
        chk("r4_g1_whack", 32'(whack), 32'h10);
        hit = 8'h01;
        ticks(4);
        chk("r4_g2_whack", 32'(whack), 32'h80);
        ticks(4);
        chk("r4_g3_whack", 32'(whack), 32'h02);
        hit = 8'h00;
        ticks(3);
        chk("r4_s42_state", 32'(state), 32'd2);
        tick();
        chk("r4_s43_state", 32'(state), 32'd3);
        chk("r4_pulses", 32'(pulses - p0), 32'd3);

        // Round 5: start ignored in PLAY, then clr while scr_inc is high
        do_start("r5");
        ticks(3);
        start = 1'b1;
        tick();
        chk("r5_ign_clr", 32'(scr_clr), 32'd0);
        chk("r5_ign_state", 32'(state), 32'd1);
        chk("r5_ign_sec", 32'(sec_left), 32'd3);
        start = 1'b0;
        mole  = 8'hFF;
        hit   = 8'h01;
        ticks(2);
        chk("r5_g_whack", 32'(whack), 32'h01);
        chk("r5_g_inc", 32'(scr_inc), 32'd1);
        clr = 1'b1;
        #1;
        chk("r5_arst_inc", 32'(scr_inc), 32'd0);
        chk("r5_arst_whack", 32'(whack), 32'h00);
        chk("r5_arst_state", 32'(state), 32'd0);
        chk("r5_arst_sec", 32'(sec_left), 32'd0);
        chk("r5_arst_clr", 32'(scr_clr), 32'd0);
        tick();
        clr = 1'b0;
        ticks(2);
        chk("r5_post_state", 32'(state), 32'd0);
        chk("r5_post_inc", 32'(scr_inc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wam_ctl.md
# wam_ctl

Game controller for Whac-A-Mole. It owns the single score-counter input: it sequences a round (clear, timed play, drain, game over), qualifies player hits against the moles currently up, and serialises simultaneous hits on eight holes into clean, separated score pulses through a round-robin arbiter. It sits between the debounced button/mole-generator logic and the ripple BCD score counter, whose count input is edge-driven and would merge concurrent hits.

## Interface
- TICK_DIV, 50_000_000: clk cycles per game second; minimum 2.
- GAME_SEC, 60: round length in seconds, 1..99.
- PULSE_W, 2: scr_inc high width and minimum low gap, in clk cycles; minimum 1.

- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a round
- mole  in  8  moles currently up, one bit per hole
- hit  in  8  debounced, synchronous button levels, one bit per hole
- scr_inc  out  1  score count pulse to the score counter
- scr_clr  out  1  one-cycle score counter clear
- whack  out  8  one-hot, one cycle: retract this mole
- state  out  2  IDLE=0, PLAY=1, DRAIN=2, OVER=3
- sec_left  out  7  seconds remaining, binary

## Operation
- Reset: state IDLE; scr_inc, scr_clr, whack, sec_left = 0; pending = 0; arbiter pointer = hole 0; tick counter = 0; hit history = 0.
- IDLE / OVER: start → state PLAY, scr_clr = 1 for that one cycle, sec_left = GAME_SEC, tick counter = 0, pending cleared.
- PLAY: hit rising edge on hole i with mole[i] = 1 sets pending[i]. Edges on holes with mole[i] = 0 are ignored. Edges on a hole already pending are ignored, so each hole holds at most one pending hit. start is ignored.
- Timer: the tick counter runs 0..TICK_DIV-1 in PLAY. At wrap, sec_left decrements. When sec_left reaches 0, the state goes to DRAIN.
- DRAIN: no new pending bits are accepted. Outstanding pending hits are still granted. When pending = 0 and the pulse engine is idle, the state goes to OVER. start is ignored.
- Arbiter: it grants only when the pulse engine is idle and pending ≠ 0. It grants the first set bit searching upward from pointer, wrapping 7→0.
- On a grant, pending[g] is cleared and whack[g] = 1 for one cycle. The pointer becomes g+1 mod 8, and the pulse engine starts.
- Pulse engine: scr_inc is high for PULSE_W cycles, then low for PULSE_W cycles, then the engine is idle. Grants therefore occur at most once every 2·PULSE_W cycles.
- A rising edge on the same hole in the same cycle its pending bit is granted is ignored.
- The counter clear on start (scr_clr) never coincides with scr_inc, because the engine is idle outside PLAY/DRAIN.
- clr at any time, including mid-pulse, forces reset values immediately. A truncated scr_inc is acceptable.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- Edge detect: hit is registered. An edge is seen when hit = 1 and the registered copy = 0 at the same clk edge.
- Pending is set at that edge (edge k).
- With the engine idle, the grant registers at edge k+1. whack and scr_inc are high after edge k+1.
- scr_inc falls after edge k+1+PULSE_W. The next grant is possible at edge k+1+2·PULSE_W.
- sec_left decrements exactly every TICK_DIV cycles. The first decrement is TICK_DIV cycles after the start edge.
- PLAY→DRAIN occurs on the edge where sec_left becomes 0. DRAIN→OVER occurs one cycle after the engine goes idle with pending = 0.

## Structure
- Shared package wam_pkg: state encodings (WAM_IDLE, WAM_PLAY, WAM_DRAIN, WAM_OVER), hole count (8), sec_left width (7).
- Sub-module wam_rr8: an 8-way round-robin arbiter.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: gnt one-hot, gnt_idx[2:0], any.
  - Purely combinational; the pointer register lives in wam_ctl.
- wam_ctl holds the FSM, the tick/second counters, edge detect, pending register, and the pulse engine.

## Test plan
All scenarios use TICK_DIV=10, GAME_SEC=3, PULSE_W=2.
- Reset and start: clr, then start → scr_clr high for 1 cycle, state=1, sec_left=3; sec_left=0 and state=2 after 30 cycles; state=3 one cycle later.
- Single valid hit: mole=8'h04, hit[2] rises → whack=8'h04 and scr_inc high two edges later for 2 cycles; exactly 1 pulse.
- Invalid hit: mole=8'h00, hit=8'hFF → no whack, scr_inc stays 0.
- Simultaneous hits: mole=8'hFF, hit rises on holes 1, 5 and 6 in the same cycle with pointer=0 → whack order 02, 20, 40; 3 pulses spaced 4 cycles apart.
  - Then a later hit on hole 1 is granted before hole 3 only if the pointer has passed 3.
- Drain: pending on 3 holes when sec_left hits 0 → state=2, all 3 pulses emitted, then state=3; a hit during DRAIN produces no pulse.
- Ignored start and async reset: start during PLAY → no scr_clr, sec_left unchanged; clr asserted while scr_inc=1 → all outputs 0 immediately, state=0.
